// File: rtl/register_file_mp_pkg.sv
// Shared defaults and helpers for the multi-port register file.
// Optional feature macro used elsewhere: RF_BYPASS_EN (write-first reads).
package rf_pkg;

    localparam int RF_AWIDTH = 5;
    localparam int RF_DWIDTH = 32;
    localparam int RF_NRD    = 2;
    localparam int RF_NWR    = 1;

    // Architectural zero register: never written, always reads 0.
    localparam int REG_ZERO  = 0;

    // Low bit of field idx in a flattened bus of width-bit fields.
    function automatic int slice_lo(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

// File: rtl/register_file_mp_if.sv
// Read/write/issue bus of the multi-port register file.
// The master drives requests; the slave (register file) returns read data and busy flags.
interface register_file_mp_if
    import rf_pkg::*;
#(
    parameter int AWIDTH = RF_AWIDTH,
    parameter int DWIDTH = RF_DWIDTH,
    parameter int NRD    = RF_NRD,
    parameter int NWR    = RF_NWR
);
    logic [NRD-1:0]        r_read_reg;
    logic [NRD*AWIDTH-1:0] r_addr_rs;
    logic [NRD*DWIDTH-1:0] r_data_out_rs;
    logic [NRD-1:0]        r_busy_rs;
    logic [NWR-1:0]        r_we;
    logic [NWR*AWIDTH-1:0] r_addr_rd;
    logic [NWR*DWIDTH-1:0] r_data_rd;
    logic                  r_issue;
    logic [AWIDTH-1:0]     r_issue_addr;

    modport master (
        output r_read_reg, r_addr_rs, r_we, r_addr_rd, r_data_rd, r_issue, r_issue_addr,
        input  r_data_out_rs, r_busy_rs
    );

    modport slave (
        input  r_read_reg, r_addr_rs, r_we, r_addr_rd, r_data_rd, r_issue, r_issue_addr,
        output r_data_out_rs, r_busy_rs
    );
endinterface

// File: rtl/register_file_mp_scoreboard.sv
// rf_scoreboard: one pending bit per register, set on issue, cleared on write-back.
// With RF_BYPASS_EN a same-cycle write (without a competing issue) masks the busy flag.
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int AWIDTH = RF_AWIDTH,
    parameter int NRD    = RF_NRD,
    parameter int NWR    = RF_NWR
) (
    input  logic                  r_clk,
    input  logic                  r_rst,
    input  logic                  issue,
    input  logic [AWIDTH-1:0]     issue_addr,
    input  logic [NWR-1:0]        we,
    input  logic [NWR*AWIDTH-1:0] addr_rd,
    input  logic [NRD*AWIDTH-1:0] addr_rs,
    output logic [NRD-1:0]        busy_rs
);
    localparam int DEPTH = 2 ** AWIDTH;

    logic [DEPTH-1:0] pending_reg;
    logic [DEPTH-1:0] pending_next;

    // Clear on write-back first, then set on issue so a new writer supersedes the old one.
    always_comb begin
        pending_next = pending_reg;
        for (int j = 0; j < NWR; j++) begin
            if (we[j]) begin
                pending_next[addr_rd[slice_lo(j, AWIDTH) +: AWIDTH]] = 1'b0;
            end
        end
        if (issue) begin
            pending_next[issue_addr] = 1'b1;
        end
        pending_next[REG_ZERO] = 1'b0;
    end

    // Pending vector state; reset discards all outstanding issues.
    always_ff @(posedge r_clk or negedge r_rst) begin
        if (!r_rst) begin
            pending_reg <= '0;
        end else begin
            pending_reg <= pending_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NRD; gi++) begin : g_busy
            logic [AWIDTH-1:0] ra;
            assign ra = addr_rs[slice_lo(gi, AWIDTH) +: AWIDTH];
`ifdef RF_BYPASS_EN
            logic wr_hit;
            logic iss_hit;

            // Any write port retiring this read address in the current cycle.
            always_comb begin
                wr_hit = 1'b0;
                for (int j = 0; j < NWR; j++) begin
                    if (we[j] && addr_rd[slice_lo(j, AWIDTH) +: AWIDTH] == ra) begin
                        wr_hit = 1'b1;
                    end
                end
            end

            assign iss_hit     = issue && (issue_addr == ra);
            assign busy_rs[gi] = pending_reg[ra] && !(wr_hit && !iss_hit);
`else
            assign busy_rs[gi] = pending_reg[ra];
`endif
        end
    endgenerate

endmodule

// File: rtl/register_file_mp.sv
// register_file_mp: NRD registered read ports, NWR write ports, register 0 hardwired to zero,
// plus an issue scoreboard for RAW hazard detection.
// Macro RF_BYPASS_EN: defined -> write-first reads; undefined -> read-first reads.
module register_file_mp
    import rf_pkg::*;
#(
    parameter int AWIDTH = RF_AWIDTH,
    parameter int DWIDTH = RF_DWIDTH,
    parameter int NRD    = RF_NRD,
    parameter int NWR    = RF_NWR
) (
    input  logic              r_clk,
    input  logic              r_rst,
    register_file_mp_if.slave bus
);
    localparam int DEPTH = 2 ** AWIDTH;
    localparam logic [AWIDTH-1:0] ZERO_ADDR = AWIDTH'(REG_ZERO);

    logic [AWIDTH-1:0] waddr   [NWR];
    logic [DWIDTH-1:0] wdata   [NWR];
    logic [DWIDTH-1:0] mem_reg [DEPTH];

    genvar gi;
    generate
        for (gi = 0; gi < NWR; gi++) begin : g_wr
            assign waddr[gi] = bus.r_addr_rd[slice_lo(gi, AWIDTH) +: AWIDTH];
            assign wdata[gi] = bus.r_data_rd[slice_lo(gi, DWIDTH) +: DWIDTH];
        end
    endgenerate

    // Array update: ports applied in ascending order so the highest index wins; entry 0 is never written.
    always_ff @(posedge r_clk or negedge r_rst) begin
        if (!r_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
        end else begin
            for (int j = 0; j < NWR; j++) begin
                if (bus.r_we[j] && waddr[j] != ZERO_ADDR) begin
                    mem_reg[waddr[j]] <= wdata[j];
                end
            end
        end
    end

    generate
        for (gi = 0; gi < NRD; gi++) begin : g_rd
            logic [AWIDTH-1:0] raddr;
            logic [DWIDTH-1:0] rd_next;
            logic [DWIDTH-1:0] rd_reg;

            assign raddr = bus.r_addr_rs[slice_lo(gi, AWIDTH) +: AWIDTH];

            // Value captured by this read port at the next edge (hold when not enabled).
            always_comb begin
                rd_next = rd_reg;
                if (bus.r_read_reg[gi]) begin
                    rd_next = mem_reg[raddr];
`ifdef RF_BYPASS_EN
                    for (int j = 0; j < NWR; j++) begin
                        if (bus.r_we[j] && waddr[j] == raddr) begin
                            rd_next = wdata[j];
                        end
                    end
`endif
                    if (raddr == ZERO_ADDR) begin
                        rd_next = '0;
                    end
                end
            end

            // Registered read output.
            always_ff @(posedge r_clk or negedge r_rst) begin
                if (!r_rst) begin
                    rd_reg <= '0;
                end else begin
                    rd_reg <= rd_next;
                end
            end

            assign bus.r_data_out_rs[slice_lo(gi, DWIDTH) +: DWIDTH] = rd_reg;
        end
    endgenerate

    rf_scoreboard #(
        .AWIDTH (AWIDTH),
        .NRD    (NRD),
        .NWR    (NWR)
    ) u_scoreboard (
        .r_clk      (r_clk),
        .r_rst      (r_rst),
        .issue      (bus.r_issue),
        .issue_addr (bus.r_issue_addr),
        .we         (bus.r_we),
        .addr_rd    (bus.r_addr_rd),
        .addr_rs    (bus.r_addr_rs),
        .busy_rs    (bus.r_busy_rs)
    );

endmodule

// File: tb/tb_register_file_mp.sv
// Testbench for register_file_mp (NRD=2, NWR=2). Stimulus pushes expected read data into a
// queue; a monitor pops and compares after every edge that follows issued stimulus.
// Honours RF_BYPASS_EN for the expected same-edge read/write behaviour.
module tb_register_file_mp;
    localparam int AW    = 5;
    localparam int DW    = 32;
    localparam int NR    = 2;
    localparam int NW    = 2;
    localparam int DEPTH = 32;
`ifdef RF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic r_clk = 1'b0;
    logic r_rst = 1'b1;
    always #5 r_clk = ~r_clk;

    register_file_mp_if #(.AWIDTH(AW), .DWIDTH(DW), .NRD(NR), .NWR(NW)) bus ();

    register_file_mp #(.AWIDTH(AW), .DWIDTH(DW), .NRD(NR), .NWR(NW)) dut (
        .r_clk (r_clk),
        .r_rst (r_rst),
        .bus   (bus)
    );

    // Reference model: architectural register contents, pending flags, last read results.
    logic [DW-1:0] m_mem  [DEPTH];
    bit            m_pend [DEPTH];
    logic [DW-1:0] m_out  [NR];
    logic [DW-1:0] exp_q  [$];
    bit            launch = 1'b0;
    int            checks = 0;
    int            failures = 0;
    logic [DW-1:0] exp_word;

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            m_mem[i]  = '0;
            m_pend[i] = 1'b0;
        end
        for (int k = 0; k < NR; k++) m_out[k] = '0;
        exp_q.delete();
    endtask

    task automatic drive_idle();
        bus.r_read_reg   = '0;
        bus.r_addr_rs    = '0;
        bus.r_we         = '0;
        bus.r_addr_rd    = '0;
        bus.r_data_rd    = '0;
        bus.r_issue      = 1'b0;
        bus.r_issue_addr = '0;
    endtask

    // One clock of stimulus: check busy before the edge, queue expected read outputs, advance model.
    task automatic step(input logic [1:0] re, input logic [AW-1:0] ra0, input logic [AW-1:0] ra1,
                        input logic [1:0] we, input logic [AW-1:0] wa0, input logic [AW-1:0] wa1,
                        input logic [DW-1:0] wd0, input logic [DW-1:0] wd1,
                        input logic iss, input logic [AW-1:0] ia, input string tag);
        logic [AW-1:0] ra [NR];
        logic [AW-1:0] wa [NW];
        logic [DW-1:0] wd [NW];
        logic [DW-1:0] after [DEPTH];
        bit            exp_busy;
        bit            wr_hit;
        ra[0] = ra0; ra[1] = ra1;
        wa[0] = wa0; wa[1] = wa1;
        wd[0] = wd0; wd[1] = wd1;
        @(negedge r_clk);
        bus.r_read_reg   = re;
        bus.r_addr_rs    = {ra1, ra0};
        bus.r_we         = we;
        bus.r_addr_rd    = {wa1, wa0};
        bus.r_data_rd    = {wd1, wd0};
        bus.r_issue      = iss;
        bus.r_issue_addr = ia;
        launch = 1'b1;
        #1;
        // Register contents once this edge's writes land (later port overrides earlier).
        after = m_mem;
        for (int j = 0; j < NW; j++) begin
            if (we[j] && wa[j] != 0) after[wa[j]] = wd[j];
        end
        for (int k = 0; k < NR; k++) begin
            exp_busy = m_pend[ra[k]];
            wr_hit = 1'b0;
            for (int j = 0; j < NW; j++) if (we[j] && wa[j] == ra[k]) wr_hit = 1'b1;
            if (BYP && wr_hit && !(iss && ia == ra[k])) exp_busy = 1'b0;
            checks++;
            if (bus.r_busy_rs[k] !== exp_busy) begin
                failures++;
                $display("FAIL busy%0d [%s] addr=%0d got=%b want=%b", k, tag, ra[k], bus.r_busy_rs[k], exp_busy);
            end
            if (re[k]) begin
                if (ra[k] == 0)  m_out[k] = '0;
                else if (BYP)    m_out[k] = after[ra[k]];
                else             m_out[k] = m_mem[ra[k]];
            end
            exp_q.push_back(m_out[k]);
        end
        for (int j = 0; j < NW; j++) begin
            if (we[j] && wa[j] != 0) m_pend[wa[j]] = 1'b0;
        end
        if (iss && ia != 0) m_pend[ia] = 1'b1;
        m_mem = after;
        $display("[%0t] %s re=%b ra=%0d/%0d we=%b wa=%0d/%0d iss=%b ia=%0d exp=%h/%h",
                 $time, tag, re, ra0, ra1, we, wa0, wa1, iss, ia, m_out[0], m_out[1]);
    endtask

    // Monitor: after each edge that consumed stimulus, compare both read outputs against the queue.
    always @(posedge r_clk) begin
        if (launch) begin
            #1;
            for (int k = 0; k < NR; k++) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL rd%0d no expectation queued at %0t", k, $time);
                end else begin
                    exp_word = exp_q.pop_front();
                    if (bus.r_data_out_rs[k*DW +: DW] !== exp_word) begin
                        failures++;
                        $display("FAIL rd%0d at %0t got=%h want=%h", k, $time, bus.r_data_out_rs[k*DW +: DW], exp_word);
                    end
                end
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        checks++;
        if (bus.r_data_out_rs !== '0) begin
            failures++;
            $display("FAIL %s data_out got=%h want=0", tag, bus.r_data_out_rs);
        end
        checks++;
        if (bus.r_busy_rs !== '0) begin
            failures++;
            $display("FAIL %s busy got=%b want=00", tag, bus.r_busy_rs);
        end
    endtask

    initial begin
        drive_idle();
        model_reset();
        #1 r_rst = 1'b0;
        repeat (2) @(posedge r_clk);
        #1 check_reset_outputs("reset_hold");
        @(negedge r_clk);
        r_rst = 1'b1;

        // Fresh array reads as zero on both ports.
        for (int i = 0; i < DEPTH; i++)
            step(2'b11, 5'(i), 5'(i), 2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 1'b0, 5'd0, "rd_zero");

        // Load i*3 through port 0, then read back on both ports.
        for (int i = 0; i < DEPTH; i++)
            step(2'b00, 5'd0, 5'd0, 2'b01, 5'(i), 5'd0, 32'(i * 3), 32'd0, 1'b0, 5'd0, "load");
        for (int i = 0; i < DEPTH; i++)
            step(2'b11, 5'(i), 5'(i), 2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 1'b0, 5'd0, "rd_load");

        // Two write ports on one address: port 1 wins.
        step(2'b00, 5'd0, 5'd0, 2'b11, 5'd5, 5'd5, 32'h0000AAAA, 32'h00005555, 1'b0, 5'd0, "dual_wr");
        step(2'b11, 5'd5, 5'd5, 2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 1'b0, 5'd0, "rd5");

        // Same-edge write and read of address 7.
        step(2'b00, 5'd0, 5'd0, 2'b01, 5'd7, 5'd0, 32'h00000015, 32'd0, 1'b0, 5'd0, "pre7");
        step(2'b01, 5'd7, 5'd0, 2'b01, 5'd7, 5'd0, 32'h00001234, 32'd0, 1'b0, 5'd0, "wr_rd7");
        step(2'b11, 5'd7, 5'd7, 2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 1'b0, 5'd0, "rd7");
        // Hold: read enables low keep previous outputs.
        step(2'b00, 5'd3, 5'd4, 2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 1'b0, 5'd0, "hold");

        // Scoreboard sequence on register 9 and register 0.
        step(2'b00, 5'd9, 5'd9, 2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 1'b1, 5'd9, "iss9");
        step(2'b00, 5'd9, 5'd9, 2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 1'b0, 5'd0, "busy9");
        step(2'b00, 5'd9, 5'd9, 2'b01, 5'd9, 5'd0, 32'h00000099, 32'd0, 1'b0, 5'd0, "wr9");
        step(2'b00, 5'd9, 5'd9, 2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 1'b0, 5'd0, "clr9");
        step(2'b00, 5'd9, 5'd9, 2'b10, 5'd0, 5'd9, 32'd0, 32'h00000077, 1'b1, 5'd9, "isswr9");
        step(2'b00, 5'd9, 5'd9, 2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 1'b0, 5'd0, "still9");
        step(2'b00, 5'd0, 5'd0, 2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 1'b1, 5'd0, "iss0");
        step(2'b00, 5'd0, 5'd0, 2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 1'b0, 5'd0, "zero");

        // Randomised traffic against the model.
        for (int n = 0; n < 300; n++)
            step(2'($urandom), 5'($urandom), 5'($urandom), 2'($urandom), 5'($urandom), 5'($urandom),
                 32'($urandom), 32'($urandom), 1'($urandom_range(3, 0) == 0), 5'($urandom), "rand");

        // Reset mid-burst: make outputs and a pending bit non-zero first.
        step(2'b00, 5'd0, 5'd0, 2'b01, 5'd20, 5'd0, 32'hDEAD0001, 32'd0, 1'b1, 5'd21, "prep");
        step(2'b11, 5'd20, 5'd21, 2'b01, 5'd22, 5'd0, 32'h00000A01, 32'd0, 1'b0, 5'd0, "burst1");
        step(2'b11, 5'd20, 5'd21, 2'b01, 5'd23, 5'd0, 32'h00000A02, 32'd0, 1'b0, 5'd0, "burst2");
        step(2'b11, 5'd20, 5'd21, 2'b01, 5'd24, 5'd0, 32'h00000A03, 32'd0, 1'b0, 5'd0, "burst3");
        @(posedge r_clk);
        #3;
        launch = 1'b0;
        r_rst  = 1'b0;
        #1 check_reset_outputs("reset_async");
        // Remaining burst writes land while reset is held and must be discarded.
        for (int i = 0; i < 3; i++) begin
            @(negedge r_clk);
            bus.r_we      = 2'b01;
            bus.r_addr_rd = {5'd0, 5'(25 + i)};
            bus.r_data_rd = {32'd0, 32'(32'h00000B00 + i)};
            bus.r_issue   = 1'b1;
            bus.r_issue_addr = 5'(25 + i);
        end
        @(negedge r_clk);
        drive_idle();
        r_rst = 1'b1;
        model_reset();
        for (int i = 20; i < 28; i += 2)
            step(2'b11, 5'(i), 5'(i + 1), 2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 1'b0, 5'd0, "post_rst");

        @(negedge r_clk);
        launch = 1'b0;
        drive_idle();
        repeat (2) @(posedge r_clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL leftover_expectations got=%0d want=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
